// File: rtl/ddr_channel_arb_n_if.sv
// ddr_channel_arb_n_if: the signal bundle between the L1-side requesters, the channel arbiter and
// the single DDR command port.
//   slave  : the arbiter's view (takes requests, issues DDR commands, returns responses)
//   master : the environment's view (requesters plus DDR controller)
// Request buses are packed per channel: channel i sits at [i*W +: W].
interface ddr_channel_arb_n_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_index;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*DATA_W-1:0] req_wmask;
  logic [NUM_CH-1:0]        rsp_done;
  logic [DATA_W-1:0]        rsp_rdata;

  logic                     ddr_chip_enable;
  logic [ADDR_W-1:0]        ddr_index;
  logic                     ddr_write_enable;
  logic                     ddr_burst_mode;
  logic [DATA_W-1:0]        ddr_write_mask;
  logic [DATA_W-1:0]        ddr_write_data;
  logic [DATA_W-1:0]        ddr_read_data;
  logic                     ddr_operation_done;
  logic                     ddr_ready;

  modport slave (
    input  req_valid, req_index, req_write, req_wdata, req_wmask,
    input  ddr_read_data, ddr_operation_done, ddr_ready,
    output req_ready, rsp_done, rsp_rdata,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_write_mask, ddr_write_data
  );

  modport master (
    output req_valid, req_index, req_write, req_wdata, req_wmask,
    output ddr_read_data, ddr_operation_done, ddr_ready,
    input  req_ready, rsp_done, rsp_rdata,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_write_mask, ddr_write_data
  );
endinterface

// File: rtl/ddr_channel_arb_n.sv
// ddr_channel_arb_n: serialises NUM_CH cache-side requesters onto one DDR command port, one
// transaction in flight at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Ports:
//   clock   : core clock
//   reset   : synchronous active-high reset
//   arb_bus : ddr_channel_arb_n_if.slave -- request/response buses and the DDR command port
// ARB_MODE 0 = fixed priority (channel 0 highest), 1 = round-robin from a rotating pointer.
// BURST_MASK[i] marks channels whose reads are issued in burst mode.
module ddr_channel_arb_n #(
  parameter int unsigned       NUM_CH     = 2,
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DATA_W     = 512,
  parameter int unsigned       ARB_MODE   = 1,
  parameter logic [NUM_CH-1:0] BURST_MASK = 'b01
) (
  input logic                clock,
  input logic                reset,
  ddr_channel_arb_n_if.slave arb_bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0]   index_q;
  logic                write_q;
  logic                burst_q;
  logic [DATA_W-1:0]   wdata_q, wmask_q, rdata_q;

  logic                win_valid;
  logic [CH_W-1:0]     win_idx;
  logic [ADDR_W-1:0]   sel_index;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata, sel_wmask;

  logic                latch, capture, chip_enable;
  logic [NUM_CH-1:0]   ready, done;

  // Winner selection and mux of the winner's request fields.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    // Lowest valid channel overall: the fixed-priority pick and the wrap-around fallback.
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (arb_bus.req_valid[k]) begin
        win_valid = 1'b1;
        win_idx   = CH_W'(k);
      end
    end
    // Round-robin: lowest valid channel at or after the pointer overrides the fallback.
    if (ARB_MODE != 0) begin
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
        if (arb_bus.req_valid[k] && (CH_W'(k) >= ptr_q)) begin
          win_idx = CH_W'(k);
        end
      end
    end

    sel_index = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (win_idx == CH_W'(k)) begin
        sel_index = arb_bus.req_index[k*ADDR_W +: ADDR_W];
        sel_write = arb_bus.req_write[k];
        sel_wdata = arb_bus.req_wdata[k*DATA_W +: DATA_W];
        sel_wmask = arb_bus.req_wmask[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and strobes; strobes stay low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    latch       = 1'b0;
    capture     = 1'b0;
    chip_enable = 1'b0;
    ready       = '0;
    done        = '0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            ready[win_idx] = 1'b1;
            latch          = 1'b1;
            state_d        = StIssue;
          end
        end
        StIssue: begin
          if (arb_bus.ddr_ready) begin
            chip_enable = 1'b1;
            state_d     = StWait;
          end
        end
        StWait: begin
          if (arb_bus.ddr_operation_done) begin
            capture = ~write_q;
            state_d = StResp;
          end
        end
        StResp: begin
          done[ch_q] = 1'b1;
          if (ARB_MODE != 0) begin
            ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      ch_q    <= '0;
      index_q <= '0;
      write_q <= 1'b0;
      burst_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (latch) begin
        ch_q    <= win_idx;
        index_q <= sel_index;
        write_q <= sel_write;
        // Burst only for reads on burst-capable channels; fixed for the whole transaction.
        burst_q <= BURST_MASK[win_idx] & ~sel_write;
        wdata_q <= sel_wdata;
        wmask_q <= sel_wmask;
      end
      if (capture) begin
        rdata_q <= arb_bus.ddr_read_data;
      end
    end
  end

  assign arb_bus.req_ready        = ready;
  assign arb_bus.rsp_done         = done;
  assign arb_bus.rsp_rdata        = rdata_q;
  assign arb_bus.ddr_chip_enable  = chip_enable;
  assign arb_bus.ddr_index        = index_q;
  assign arb_bus.ddr_write_enable = write_q;
  assign arb_bus.ddr_burst_mode   = burst_q;
  assign arb_bus.ddr_write_mask   = wmask_q;
  assign arb_bus.ddr_write_data   = wdata_q;

endmodule

// File: tb/tb_ddr_channel_arb_n.sv
// Bench for ddr_channel_arb_n: three instances share one stimulus stream
//   inst 0: NUM_CH=2, round-robin, BURST_MASK=01 (directed table + corner sequences)
//   inst 1: NUM_CH=4, round-robin, BURST_MASK=0101
//   inst 2: NUM_CH=4, fixed priority, BURST_MASK=0011
// A transaction-level reference model tracks every instance cycle by cycle.
module tb_ddr_channel_arb_n;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int NI = 3;
  localparam int M_NCH [NI] = '{2, 4, 4};
  localparam int M_MODE [NI] = '{1, 1, 0};
  localparam logic [3:0] M_BMASK [NI] = '{4'b0001, 4'b0101, 4'b0011};

  localparam logic [AW-1:0] IDX0 = 32'h8000_0040;
  localparam logic [AW-1:0] IDX1 = 32'h0000_0100;
  localparam logic [DW-1:0] A5   = {8{8'hA5}};
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] WD1  = 64'h1234;
  localparam logic [DW-1:0] DEAD = 64'hDEAD;
  localparam logic [DW-1:0] RVAL = 64'h0123_4567_89AB_CDEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [3:0]      valid, write;
  logic [4*AW-1:0] index_p;
  logic [4*DW-1:0] wdata_p, wmask_p;
  logic            ddr_ready, ddr_done;
  logic [DW-1:0]   ddr_rdata;

  ddr_channel_arb_n_if #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW)) if_a ();
  ddr_channel_arb_n_if #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW)) if_b ();
  ddr_channel_arb_n_if #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW)) if_c ();

  ddr_channel_arb_n #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
                      .BURST_MASK(2'b01)) dut_a (.clock(clock), .reset(reset), .arb_bus(if_a));
  ddr_channel_arb_n #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
                      .BURST_MASK(4'b0101)) dut_b (.clock(clock), .reset(reset), .arb_bus(if_b));
  ddr_channel_arb_n #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0),
                      .BURST_MASK(4'b0011)) dut_c (.clock(clock), .reset(reset), .arb_bus(if_c));

  assign if_a.req_valid = valid[1:0];
  assign if_a.req_write = write[1:0];
  assign if_a.req_index = index_p[2*AW-1:0];
  assign if_a.req_wdata = wdata_p[2*DW-1:0];
  assign if_a.req_wmask = wmask_p[2*DW-1:0];
  assign if_b.req_valid = valid;
  assign if_b.req_write = write;
  assign if_b.req_index = index_p;
  assign if_b.req_wdata = wdata_p;
  assign if_b.req_wmask = wmask_p;
  assign if_c.req_valid = valid;
  assign if_c.req_write = write;
  assign if_c.req_index = index_p;
  assign if_c.req_wdata = wdata_p;
  assign if_c.req_wmask = wmask_p;
  assign if_a.ddr_ready = ddr_ready;
  assign if_b.ddr_ready = ddr_ready;
  assign if_c.ddr_ready = ddr_ready;
  assign if_a.ddr_operation_done = ddr_done;
  assign if_b.ddr_operation_done = ddr_done;
  assign if_c.ddr_operation_done = ddr_done;
  assign if_a.ddr_read_data = ddr_rdata;
  assign if_b.ddr_read_data = ddr_rdata;
  assign if_c.ddr_read_data = ddr_rdata;

  logic [3:0]    o_ready [NI];
  logic [3:0]    o_done  [NI];
  logic          o_ce    [NI];
  logic          o_we    [NI];
  logic          o_burst [NI];
  logic [AW-1:0] o_idx   [NI];
  logic [DW-1:0] o_wd    [NI];
  logic [DW-1:0] o_wm    [NI];
  logic [DW-1:0] o_rdata [NI];

  assign o_ready[0] = {2'b00, if_a.req_ready};
  assign o_ready[1] = if_b.req_ready;
  assign o_ready[2] = if_c.req_ready;
  assign o_done[0]  = {2'b00, if_a.rsp_done};
  assign o_done[1]  = if_b.rsp_done;
  assign o_done[2]  = if_c.rsp_done;
  assign o_ce[0] = if_a.ddr_chip_enable;
  assign o_ce[1] = if_b.ddr_chip_enable;
  assign o_ce[2] = if_c.ddr_chip_enable;
  assign o_we[0] = if_a.ddr_write_enable;
  assign o_we[1] = if_b.ddr_write_enable;
  assign o_we[2] = if_c.ddr_write_enable;
  assign o_burst[0] = if_a.ddr_burst_mode;
  assign o_burst[1] = if_b.ddr_burst_mode;
  assign o_burst[2] = if_c.ddr_burst_mode;
  assign o_idx[0] = if_a.ddr_index;
  assign o_idx[1] = if_b.ddr_index;
  assign o_idx[2] = if_c.ddr_index;
  assign o_wd[0] = if_a.ddr_write_data;
  assign o_wd[1] = if_b.ddr_write_data;
  assign o_wd[2] = if_c.ddr_write_data;
  assign o_wm[0] = if_a.ddr_write_mask;
  assign o_wm[1] = if_b.ddr_write_mask;
  assign o_wm[2] = if_c.ddr_write_mask;
  assign o_rdata[0] = if_a.rsp_rdata;
  assign o_rdata[1] = if_b.rsp_rdata;
  assign o_rdata[2] = if_c.rsp_rdata;

  // Reference model: the one outstanding transaction and its progress.
  typedef struct {
    bit            busy;
    bit            issued;
    bit            finished;
    int            ch;
    int            ptr;
    logic          we;
    logic          burst;
    logic [AW-1:0] idx;
    logic [DW-1:0] wd;
    logic [DW-1:0] wm;
    logic [DW-1:0] rdata;
  } mstate_t;

  mstate_t ms [NI];
  int checks;
  int failures;

  task automatic chk(input string name, input int n, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (%0d) got=%0h want=%0h t=%0t", name, n, act, exp, $time);
    end
  endtask

  function automatic int pick(input int i);
    int n = M_NCH[i];
    for (int k = 0; k < n; k++) begin
      int c = (M_MODE[i] == 1) ? (ms[i].ptr + k) % n : k;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_check(input int i);
    logic [3:0] er, ed;
    logic ece;
    int w;
    er = '0;
    ed = '0;
    ece = 1'b0;
    if (!reset) begin
      if (!ms[i].busy) begin
        w = pick(i);
        if (w >= 0) er[w] = 1'b1;
      end else if (!ms[i].issued) begin
        ece = ddr_ready;
      end else if (ms[i].finished) begin
        ed[ms[i].ch] = 1'b1;
      end
    end
    chk("m_req_ready", i, DW'(o_ready[i]), DW'(er));
    chk("m_rsp_done", i, DW'(o_done[i]), DW'(ed));
    chk("m_chip_enable", i, DW'(o_ce[i]), DW'(ece));
    chk("m_rsp_rdata", i, o_rdata[i], ms[i].rdata);
    chk("m_ddr_index", i, DW'(o_idx[i]), DW'(ms[i].idx));
    chk("m_write_en", i, DW'(o_we[i]), DW'(ms[i].we));
    chk("m_burst", i, DW'(o_burst[i]), DW'(ms[i].burst));
    chk("m_wdata", i, o_wd[i], ms[i].wd);
    chk("m_wmask", i, o_wm[i], ms[i].wm);
  endtask

  task automatic model_update(input int i);
    int w;
    logic [3:0] bm;
    bm = M_BMASK[i];
    if (reset) begin
      ms[i] = '{default: '0};
    end else if (!ms[i].busy) begin
      w = pick(i);
      if (w >= 0) begin
        ms[i].busy     = 1'b1;
        ms[i].issued   = 1'b0;
        ms[i].finished = 1'b0;
        ms[i].ch       = w;
        ms[i].we       = write[w];
        ms[i].burst    = bm[w] & ~write[w];
        ms[i].idx      = index_p[w*AW +: AW];
        ms[i].wd       = wdata_p[w*DW +: DW];
        ms[i].wm       = wmask_p[w*DW +: DW];
      end
    end else if (!ms[i].issued) begin
      if (ddr_ready) ms[i].issued = 1'b1;
    end else if (!ms[i].finished) begin
      if (ddr_done) begin
        ms[i].finished = 1'b1;
        if (!ms[i].we) ms[i].rdata = ddr_rdata;
      end
    end else begin
      ms[i].busy = 1'b0;
      if (M_MODE[i] == 1) ms[i].ptr = (ms[i].ch + 1) % M_NCH[i];
    end
  endtask

  // Inputs change at the falling edge; outputs are compared 1ns later.
  task automatic settle();
    #1;
    for (int i = 0; i < NI; i++) model_check(i);
  endtask

  task automatic advance();
    for (int i = 0; i < NI; i++) model_update(i);
    @(negedge clock);
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    write;
    logic          rdy;
    logic          done;
    logic [DW-1:0] rdata;
    logic [1:0]    e_ready;
    logic [1:0]    e_done;
    logic          e_ce;
    logic          e_we;
    logic          e_burst;
    logic [AW-1:0] e_idx;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_wm;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t tbl [13];
  int gb[$];
  int gc[$];
  int dcnt [4];
  int ce_cnt;
  bit seen;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    valid = '0;
    write = '0;
    index_p = '0;
    wdata_p = '0;
    wmask_p = '0;
    ddr_ready = 1'b0;
    ddr_done = 1'b0;
    ddr_rdata = '0;
    for (int i = 0; i < NI; i++) ms[i] = '{default: '0};

    // Single ch0 read with done 5 cycles after chip_enable, then a ch1 write.
    tbl[0] = '{2'b01, 2'b00, 1'b0, 1'b0, '0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0};
    tbl[1] = '{2'b00, 2'b00, 1'b1, 1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, IDX0, '0, '0, '0};
    for (int r = 2; r < 6; r++)
      tbl[r] = '{2'b00, 2'b00, 1'b1, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, IDX0, '0, '0, '0};
    tbl[6] = '{2'b00, 2'b00, 1'b1, 1'b1, A5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, IDX0, '0, '0, '0};
    tbl[7] = '{2'b00, 2'b00, 1'b1, 1'b0, '0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, IDX0, '0, '0, A5};
    tbl[8] = '{2'b10, 2'b10, 1'b0, 1'b0, '0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, IDX0, '0, '0, A5};
    tbl[9] = '{2'b00, 2'b00, 1'b1, 1'b0, '0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, IDX1, WD1, ONES, A5};
    tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b1, DEAD, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, IDX1, WD1, ONES,
                A5};
    tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b0, '0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, IDX1, WD1, ONES, A5};
    tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, IDX1, WD1, ONES, A5};

    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b0;

    index_p[0*AW +: AW] = IDX0;
    index_p[1*AW +: AW] = IDX1;
    wdata_p[1*DW +: DW] = WD1;
    wmask_p[1*DW +: DW] = ONES;
    for (int r = 0; r < 13; r++) begin
      valid = {2'b00, tbl[r].valid};
      write = {2'b00, tbl[r].write};
      ddr_ready = tbl[r].rdy;
      ddr_done = tbl[r].done;
      ddr_rdata = tbl[r].rdata;
      settle();
      chk("tbl_req_ready", r, DW'(if_a.req_ready), DW'(tbl[r].e_ready));
      chk("tbl_rsp_done", r, DW'(if_a.rsp_done), DW'(tbl[r].e_done));
      chk("tbl_chip_enable", r, DW'(if_a.ddr_chip_enable), DW'(tbl[r].e_ce));
      chk("tbl_write_en", r, DW'(if_a.ddr_write_enable), DW'(tbl[r].e_we));
      chk("tbl_burst", r, DW'(if_a.ddr_burst_mode), DW'(tbl[r].e_burst));
      chk("tbl_index", r, DW'(if_a.ddr_index), DW'(tbl[r].e_idx));
      chk("tbl_wdata", r, if_a.ddr_write_data, tbl[r].e_wd);
      chk("tbl_wmask", r, if_a.ddr_write_mask, tbl[r].e_wm);
      chk("tbl_rsp_rdata", r, if_a.rsp_rdata, tbl[r].e_rdata);
      advance();
    end

    // ddr_ready held low for 10 cycles in ISSUE.
    valid = 4'b0001;
    write = '0;
    ddr_ready = 1'b0;
    ddr_done = 1'b0;
    cycle();
    valid = '0;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("stall_ce_low", k, DW'(if_a.ddr_chip_enable), '0);
      chk("stall_index", k, DW'(if_a.ddr_index), DW'(IDX0));
      advance();
    end
    ddr_ready = 1'b1;
    ce_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      if (if_a.ddr_chip_enable) ce_cnt++;
      advance();
    end
    chk("stall_ce_once", 0, DW'(ce_cnt), 64'd1);
    ddr_done = 1'b1;
    ddr_rdata = RVAL;
    cycle();
    ddr_done = 1'b0;
    settle();
    chk("stall_rsp_done", 0, DW'(if_a.rsp_done), 64'd1);
    chk("stall_rdata", 0, if_a.rsp_rdata, RVAL);
    advance();

    // Reset while waiting on DDR, then a stray completion.
    valid = 4'b0001;
    cycle();
    valid = '0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    chk("rst_req_ready", 0, DW'(if_a.req_ready), '0);
    chk("rst_rsp_done", 0, DW'(if_a.rsp_done), '0);
    chk("rst_ce", 0, DW'(if_a.ddr_chip_enable), '0);
    chk("rst_we", 0, DW'(if_a.ddr_write_enable), '0);
    chk("rst_burst", 0, DW'(if_a.ddr_burst_mode), '0);
    chk("rst_index", 0, DW'(if_a.ddr_index), '0);
    chk("rst_wdata", 0, if_a.ddr_write_data, '0);
    chk("rst_wmask", 0, if_a.ddr_write_mask, '0);
    chk("rst_rdata", 0, if_a.rsp_rdata, '0);
    ddr_done = 1'b1;
    ddr_rdata = ONES;
    advance();
    ddr_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stray_no_done", k, DW'(if_a.rsp_done), '0);
      chk("stray_rdata", k, if_a.rsp_rdata, '0);
      advance();
    end
    valid = 4'b0011;
    settle();
    chk("rst_ptr_zero", 0, DW'(if_a.req_ready), 64'd1);
    advance();
    valid = '0;
    ddr_done = 1'b1;
    ddr_rdata = A5;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      settle();
      if (if_a.rsp_done != 2'b00) begin
        seen = 1'b1;
        chk("post_rst_done_ch", 0, DW'(if_a.rsp_done), 64'd1);
      end
      advance();
    end
    chk("post_rst_served", 0, DW'(seen), 64'd1);

    // All four channels requesting continuously.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    valid = 4'b1111;
    write = '0;
    ddr_ready = 1'b1;
    ddr_done = 1'b1;
    for (int c = 0; c < 4; c++) dcnt[c] = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (if_b.req_ready != 0) gb.push_back(onehot_idx(if_b.req_ready));
      if (if_c.req_ready != 0) gc.push_back(onehot_idx(if_c.req_ready));
      if (k < 16) for (int c = 0; c < 4; c++) if (if_b.rsp_done[c]) dcnt[c]++;
      advance();
    end
    chk("rr_grant_count", 1, DW'(gb.size()), 64'd5);
    for (int g = 0; g < gb.size() && g < 5; g++) chk("rr_grant_order", g, DW'(gb[g]), DW'(g % 4));
    for (int c = 0; c < 4; c++) chk("rr_done_once", c, DW'(dcnt[c]), 64'd1);
    chk("fp_grant_count", 2, DW'(gc.size()), 64'd5);
    for (int g = 0; g < gc.size(); g++) chk("fp_all_ch0", g, DW'(gc[g]), '0);

    // Fixed priority with ch0 and ch2 both requesting.
    gc.delete();
    valid = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (if_c.req_ready != 0) gc.push_back(onehot_idx(if_c.req_ready));
      advance();
    end
    chk("fp02_grant_count", 2, DW'(gc.size()), 64'd3);
    for (int g = 0; g < gc.size(); g++) chk("fp02_ch0_only", g, DW'(gc[g]), '0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      valid = 4'($urandom);
      write = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        index_p[c*AW +: AW] = $urandom;
        wdata_p[c*DW +: DW] = {$urandom, $urandom};
        wmask_p[c*DW +: DW] = {$urandom, $urandom};
      end
      ddr_ready = ($urandom_range(9) < 7);
      ddr_done = ($urandom_range(9) < 3);
      ddr_rdata = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_channel_arb_n.md
Name: ddr_channel_arb_n

Overview:
- N-requester arbiter that serialises cache-side bus transactions onto the single DDR port.
- Next-generation replacement for the fixed two-channel icache/dcache arbiter. Room for extra requesters such as a PTW or prefetcher.
- Adds parametrised channel count, selectable fixed-priority or round-robin arbitration, and per-channel burst policy.
- Sits in the core top between the L1 caches and the DDR controller.

Parameters:
NUM_CH, 2, number of requester channels (2..8)
ADDR_W, 64, request index width
DATA_W, 512, cacheline data/mask width
ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
BURST_MASK, 'b01, bit i set = channel i always issues burst mode (channel 0 = icache)

Ports:
clock  in  1  core clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel accept strobe
req_index  in  NUM_CH*ADDR_W  packed; channel i at [i*ADDR_W +: ADDR_W]
req_write  in  NUM_CH  1 = write, 0 = read
req_wdata  in  NUM_CH*DATA_W  packed write data
req_wmask  in  NUM_CH*DATA_W  packed write mask
rsp_done  out  NUM_CH  one-cycle completion pulse
rsp_rdata  out  DATA_W  shared read data, valid with any rsp_done
ddr_chip_enable  out  1  one-cycle command strobe
ddr_index  out  ADDR_W  command address
ddr_write_enable  out  1  1 = write
ddr_burst_mode  out  1  burst command
ddr_write_mask  out  DATA_W  write mask
ddr_write_data  out  DATA_W  write data
ddr_read_data  in  DATA_W  DDR read return
ddr_operation_done  in  1  DDR completion pulse
ddr_ready  in  1  DDR can accept a command

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE; round-robin pointer = 0.
  - All outputs 0: req_ready, rsp_done, rsp_rdata, ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_mask, ddr_write_data.
- FSM states IDLE, ISSUE, WAIT, RESP. Exactly one transaction is outstanding at a time.
- IDLE:
  - If any req_valid, select winner w.
  - ARB_MODE 0: lowest-index valid channel wins.
  - ARB_MODE 1: first valid channel at or after pointer, wrapping modulo NUM_CH.
  - In that same cycle, drive req_ready[w]=1 (one-hot, combinational from registered state and inputs).
  - Latch w, index, write, wdata, wmask; go to ISSUE.
  - Requesters must hold request fields stable while valid and not accepted.
- ISSUE:
  - When ddr_ready=1, pulse ddr_chip_enable for exactly one cycle and go to WAIT.
  - ddr_index, ddr_write_enable, ddr_write_data and ddr_write_mask come from the latched fields.
  - ddr_burst_mode = BURST_MASK[w] & ~write.
  - If ddr_ready=0, stay in ISSUE with chip_enable low.
  - ddr_* command fields hold their values from ISSUE through WAIT.
- WAIT:
  - On ddr_operation_done, register ddr_read_data into rsp_rdata (reads only; writes leave rsp_rdata unchanged).
  - Go to RESP.
  - ddr_operation_done in any state other than WAIT is ignored.
- RESP:
  - rsp_done[w]=1 for one cycle.
  - ARB_MODE 1: pointer = (w+1) mod NUM_CH.
  - Return to IDLE. No new grant is made in RESP.
- rsp_rdata holds until the next read completion.
- Minimum latency, valid accepted to rsp_done: 3 cycles plus DDR latency. With ddr_ready=1 and done arriving the cycle after chip_enable, rsp_done follows valid by 3 cycles.
- req_valid deasserting after acceptance has no effect; the latched transaction completes.
- Reset mid-transaction:
  - Abandons the transaction immediately; no rsp_done is issued.
  - A late ddr_operation_done after reset is ignored (FSM is in IDLE).
- Simultaneous requests on all channels, ARB_MODE 1: each channel is served once per NUM_CH transactions, giving starvation freedom.
- NUM_CH=1 degenerates to pass-through with the same FSM timing.

Test Plan:
- Single read, ch0, index 0x8000_0040, ddr_ready=1, done 5 cycles after chip_enable, rdata 0xA5.. -> req_ready[0] at cycle 0, chip_enable at cycle 1 with burst_mode=1, write_enable=0, rsp_done[0] one cycle after done, rsp_rdata=0xA5...
- ch1 write, index 0x100, mask all-ones, data 0x1234 -> ddr_write_enable=1, burst_mode=0, write_data=0x1234; rsp_done[1] pulses; rsp_rdata unchanged from previous read.
- NUM_CH=4, ARB_MODE=1, all four valid continuously -> grant order 0,1,2,3,0; each rsp_done pulses exactly once per 4 transactions.
- ARB_MODE=0, ch0 and ch2 valid continuously -> ch0 granted every time, ch2 never while ch0 remains valid.
- ddr_ready held 0 for 10 cycles in ISSUE -> chip_enable stays low, then pulses exactly once when ready rises; ddr_index stable throughout.
- Reset asserted in WAIT, then a stray ddr_operation_done -> all outputs 0, no rsp_done; the next request is served normally with the pointer at 0.
